alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 30 +++
 rtl/alu_seq_if.sv | 31 +++
 rtl/alu_seq_regfile.sv | 38 +++
 rtl/alu_sequencer.sv | 101 ++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer slice.
// Holds data/register widths, the ALU op encoding, the FSM state enum
// and the instruction word layout.
package alu_seq_pkg;

  localparam int unsigned DW   = 8;
  localparam int unsigned NREG = 4;
  localparam int unsigned AW   = 2;

  // ALU op encoding carried on alu_sel
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_SHL = 2'b10;
  localparam logic [1:0] OP_CMP = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    WB   = 2'b10
  } state_e;

  // Instruction word: [7:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2
  typedef struct packed {
    logic [1:0]    op;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
  } instr_t;

endpackage

// File: rtl/alu_seq_if.sv
// Bus bundle between the sequencer and its environment (instruction
// source, external registered ALU, write-back observer).
//   instr_valid/instr_ready/instr : instruction handshake
//   alu_a/alu_b/alu_sel/alu_y     : operands out, registered result in
//   wb_valid/wb_addr/wb_data      : register write-back strobe
// slave = sequencer side, master = environment side.
interface alu_seq_if;
  import alu_seq_pkg::*;

  logic            instr_valid;
  logic            instr_ready;
  logic [DW-1:0]   instr;
  logic [DW-1:0]   alu_a;
  logic [DW-1:0]   alu_b;
  logic [1:0]      alu_sel;
  logic [DW-1:0]   alu_y;
  logic            wb_valid;
  logic [AW-1:0]   wb_addr;
  logic [DW-1:0]   wb_data;

  modport slave (
    input  instr_valid, instr, alu_y,
    output instr_ready, alu_a, alu_b, alu_sel, wb_valid, wb_addr, wb_data
  );

  modport master (
    output instr_valid, instr, alu_y,
    input  instr_ready, alu_a, alu_b, alu_sel, wb_valid, wb_addr, wb_data
  );

endinterface

// File: rtl/alu_seq_regfile.sv
// NREG x DW register file with async active-low reset.
//   ra_addr/ra_data, rb_addr/rb_data : combinational operand reads
//   dbg_addr/dbg_data                : combinational debug read
//   we/wa/wd                         : synchronous write port
module alu_seq_regfile
  import alu_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd
);

  logic [DW-1:0] regs [NREG];

  // Storage; reads see the pre-write value during the write cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign ra_data  = regs[ra_addr];
  assign rb_data  = regs[rb_addr];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Three-state instruction sequencer driving an external registered ALU.
// IDLE accepts an instruction and registers operands, EXEC lets the ALU
// capture them, WB writes the ALU result into the register file.
//   clk, rst_n          : clock, async active-low reset
//   bus (slave)         : instruction handshake, ALU operands/result, write-back
//   rf_rd_addr/rf_rd_data : combinational debug read of the register file
//   zero_flag           : only when ALU_SEQ_ZERO_FLAG_EN is defined; (alu_y==0)
//                         captured at each write-back edge
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  alu_seq_if.slave      bus,
  input  logic [AW-1:0] rf_rd_addr,
  output logic [DW-1:0] rf_rd_data
`ifdef ALU_SEQ_ZERO_FLAG_EN
  ,
  output logic          zero_flag
`endif
);

  state_e        state_q;
  instr_t        ins;
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;
  logic          accept;

  assign ins    = instr_t'(bus.instr);
  assign accept = (state_q == IDLE) && bus.instr_valid && bus.instr_ready;

  alu_seq_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra_addr  (ins.rs1),
    .ra_data  (rs1_data),
    .rb_addr  (ins.rs2),
    .rb_data  (rs2_data),
    .dbg_addr (rf_rd_addr),
    .dbg_data (rf_rd_data),
    .we       (bus.wb_valid),
    .wa       (bus.wb_addr),
    .wd       (bus.alu_y)
  );

  // ALU result only exists during WB, so the write data follows it directly
  assign bus.wb_data = bus.wb_valid ? bus.alu_y : '0;

  // FSM with registered outputs; wb_addr doubles as the latched rd
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      bus.instr_ready <= 1'b0;
      bus.alu_a       <= '0;
      bus.alu_b       <= '0;
      bus.alu_sel     <= OP_ADD;
      bus.wb_valid    <= 1'b0;
      bus.wb_addr     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          bus.instr_ready <= 1'b1;
          if (accept) begin
            bus.alu_a       <= rs1_data;
            bus.alu_b       <= rs2_data;
            bus.alu_sel     <= ins.op;
            bus.wb_addr     <= ins.rd;
            bus.instr_ready <= 1'b0;
            state_q         <= EXEC;
          end
        end
        EXEC: begin
          bus.wb_valid <= 1'b1;
          state_q      <= WB;
        end
        WB: begin
          bus.wb_valid    <= 1'b0;
          bus.instr_ready <= 1'b1;
          state_q         <= IDLE;
        end
        default: begin
          bus.wb_valid    <= 1'b0;
          bus.instr_ready <= 1'b0;
          state_q         <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_ZERO_FLAG_EN
  // Zero flag tracks the value written at each write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_flag <= 1'b0;
    end else if (bus.wb_valid) begin
      zero_flag <= (bus.alu_y == '0);
    end
  end
`endif

endmodule
